ysyx_25040101_alu_seq: RTL and testbench

Parametrised, handshaked ALU for the nebula-core execute stage. It supersedes the purely combinational add/sub/pass-B ALU. It adds logic and compare ops, plus iterative multiply and unsigned divide/remainder. Operands arrive on a valid/ready request channel, and results leave on a valid/ready response channel. The block sits between the ctrl_unit/operand muxes and regs/ram write-back.

---
 rtl/ysyx_25040101_alu_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ysyx_25040101_alu_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040101_alu_seq.sv
// ----------------------------------------------------------------------------
// ysyx_25040101_alu_seq
//
// Handshaked ALU for the nebula-core execute stage.
//
// Requests are accepted on a valid/ready channel. Results leave on a second
// valid/ready channel.
// - Single-cycle ops (ADD, SUB, AND, OR, XOR, SLT, SLTU, PASSB, and the
//   reserved codes) produce a registered result one cycle after accept.
// - Iterative ops (MUL, DIVU, REMU) take XLEN cycles in BUSY before the
//   result is presented.
//
// Optional feature macro: ALU_SEQ_MULDIV_EN
//   defined   : shift-add multiplier and restoring divider are built.
//   undefined : codes 8..10 act as reserved (single-cycle, result 0),
//               busy_o is tied low, and no iterative datapath exists.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   in_valid_i    request valid
//   in_ready_o    request ready (accept = in_valid_i & in_ready_o)
//   op_i          4-bit operation code
//   srca_data_i   operand A
//   srcb_data_i   operand B
//   flush_i       synchronous abort of anything in flight or pending
//   out_valid_o   result valid
//   out_ready_i   consumer ready
//   alu_result_o  registered result
//   busy_o        high while an iterative op is running
// ----------------------------------------------------------------------------
module ysyx_25040101_alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] srca_data_i,
    input  logic [XLEN-1:0] srcb_data_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] alu_result_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_PASSB = 4'd7;
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_DIVU  = 4'd9;
    localparam logic [3:0] OP_REMU  = 4'd10;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              is_iter_s;    // the op being presented is iterative
    logic              iter_last_s;  // final iteration happens this cycle
    logic [XLEN-1:0]   single_res_s;
    logic [XLEN-1:0]   iter_res_s;
    logic [XLEN-1:0]   result_r;

    // Result of every op that completes in the accept cycle; anything not
    // listed (reserved codes, and 8..10 when the muldiv unit is absent) is 0.
    function automatic logic [XLEN-1:0] single_op(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] one;
        one = {{(XLEN-1){1'b0}}, 1'b1};
        case (op)
            OP_ADD:   single_op = a + b;
            OP_SUB:   single_op = a - b;
            OP_AND:   single_op = a & b;
            OP_OR:    single_op = a | b;
            OP_XOR:   single_op = a ^ b;
            OP_SLT:   single_op = ($signed(a) < $signed(b)) ? one : {XLEN{1'b0}};
            OP_SLTU:  single_op = (a < b) ? one : {XLEN{1'b0}};
            OP_PASSB: single_op = b;
            default:  single_op = {XLEN{1'b0}};
        endcase
    endfunction

    assign single_res_s = single_op(op_i, srca_data_i, srcb_data_i);

    // Ready: idle, or done and the consumer is taking the current result;
    // a flush blocks acceptance in the same cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (flush_i) begin
            in_ready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_r == ST_DONE) begin
            in_ready_s = out_ready_i;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign in_ready_o = in_ready_s;
    assign accept_s   = in_valid_i & in_ready_s;

`ifdef ALU_SEQ_MULDIV_EN
    // Shared iterative datapath.
    // MUL:  opa = shifting multiplicand, opb = shifting multiplier,
    //       acc = partial product.
    // DIV:  opa = dividend shifting out / quotient shifting in,
    //       opb = divisor, acc = partial remainder.
    logic [3:0]       op_r;
    logic [XLEN-1:0]  opa_r;
    logic [XLEN-1:0]  opb_r;
    logic [XLEN-1:0]  acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0]  opa_nxt_s;
    logic [XLEN-1:0]  opb_nxt_s;
    logic [XLEN-1:0]  acc_nxt_s;
    logic [XLEN:0]    shifted_s;
    logic [XLEN-1:0]  diff_s;
    logic             ge_s;

    assign is_iter_s   = (op_i == OP_MUL) | (op_i == OP_DIVU) | (op_i == OP_REMU);
    assign iter_last_s = (cnt_r == CNT_W'(1));
    assign busy_o      = (state_r == ST_BUSY);

    // One multiply or restoring-divide step. A zero divisor always "fits",
    // so the quotient fills with ones and the remainder ends up as the
    // dividend, with no special-case logic.
    always_comb begin
        shifted_s  = {acc_r, opa_r[XLEN-1]};
        ge_s       = (shifted_s >= {1'b0, opb_r});
        diff_s     = shifted_s[XLEN-1:0] - opb_r;
        opa_nxt_s  = opa_r;
        opb_nxt_s  = opb_r;
        acc_nxt_s  = acc_r;
        iter_res_s = {XLEN{1'b0}};
        if (op_r == OP_MUL) begin
            acc_nxt_s  = acc_r + (opb_r[0] ? opa_r : {XLEN{1'b0}});
            opa_nxt_s  = opa_r << 1;
            opb_nxt_s  = opb_r >> 1;
            iter_res_s = acc_nxt_s;
        end else begin
            opa_nxt_s  = {opa_r[XLEN-2:0], ge_s};
            acc_nxt_s  = ge_s ? diff_s : shifted_s[XLEN-1:0];
            opb_nxt_s  = opb_r;
            iter_res_s = (op_r == OP_DIVU) ? opa_nxt_s : acc_nxt_s;
        end
    end

    // Operand capture at accept and one iteration per BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r  <= 4'd0;
            opa_r <= {XLEN{1'b0}};
            opb_r <= {XLEN{1'b0}};
            acc_r <= {XLEN{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            op_r  <= op_i;
            opa_r <= srca_data_i;
            opb_r <= srcb_data_i;
            acc_r <= {XLEN{1'b0}};
            cnt_r <= CNT_W'(XLEN);
        end else if (state_r == ST_BUSY) begin
            opa_r <= opa_nxt_s;
            opb_r <= opb_nxt_s;
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end
`else
    assign is_iter_s   = 1'b0;
    assign iter_last_s = 1'b1;
    assign iter_res_s  = {XLEN{1'b0}};
    assign busy_o      = 1'b0;
`endif

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        if (flush_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = is_iter_s ? ST_BUSY : ST_DONE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (iter_last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (accept_s) begin
                        state_nxt_s = is_iter_s ? ST_BUSY : ST_DONE;
                    end else if (out_ready_i) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Result register: loaded at accept for single-cycle ops, or on the
    // final iteration for iterative ops; otherwise it holds for the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r <= {XLEN{1'b0}};
        end else if (flush_i) begin
            result_r <= {XLEN{1'b0}};
        end else if (accept_s && !is_iter_s) begin
            result_r <= single_res_s;
        end else if ((state_r == ST_BUSY) && iter_last_s) begin
            result_r <= iter_res_s;
        end
    end

    assign out_valid_o  = (state_r == ST_DONE);
    assign alu_result_o = result_r;

endmodule

// File: tb/tb_ysyx_25040101_alu_seq.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for ysyx_25040101_alu_seq (XLEN = 32).
//
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// The iterative cases are selected by ALU_SEQ_MULDIV_EN, matching the RTL
// build.
// ----------------------------------------------------------------------------
module tb_ysyx_25040101_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;

    ysyx_25040101_alu_seq #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .op_i         (op),
        .srca_data_i  (srca),
        .srcb_data_i  (srcb),
        .flush_i      (flush),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .alu_result_o (result),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if observed differs from expected.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request with out_ready held high.
    // Checks: ready at issue, busy in the first cycle after accept, latency
    // (edges from accept to out_valid), the result, busy low with valid, and
    // the drain back to idle. Operand inputs are scrambled after accept.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        in_valid  = 1'b1;
        op        = o;
        srca      = a;
        srcb      = b;
        out_ready = 1'b1;
        #1;
        chk({tag, ".rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        srca     = ~a;
        srcb     = ~b;
        chk({tag, ".busy"}, 64'(busy), (exp_lat > 1) ? 64'd1 : 64'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".res"}, 64'(result), 64'(exp));
        chk({tag, ".busy_vs_valid"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, ".drain"}, 64'(out_valid), 64'd0);
    endtask

    // Back-to-back vectors: ADD, XOR, OR, AND.
    logic [3:0]  bb_op  [4] = '{4'd0, 4'd4, 4'd3, 4'd2};
    logic [31:0] bb_a   [4] = '{32'h0000_0010, 32'hF0F0_F0F0, 32'h0000_FF00, 32'h1234_5678};
    logic [31:0] bb_b   [4] = '{32'h0000_0020, 32'hFF00_FF00, 32'h00FF_0000, 32'h0F0F_0F0F};
    logic [31:0] bb_exp [4] = '{32'h0000_0030, 32'h0FF0_0FF0, 32'h00FF_FF00, 32'h0204_0608};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 4'd0;
        srca      = 32'd0;
        srcb      = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid",  64'(out_valid), 64'd0);
        chk("rst.result", 64'(result),    64'd0);
        chk("rst.busy",   64'(busy),      64'd0);
        rst = 1'b0;
        #1;
        chk("rst.ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1;

        // Single-cycle ops.
        run_op("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
        run_op("sub",      4'd1,  32'd5,         32'd7,         32'hFFFF_FFFE, 1);
        run_op("slt",      4'd5,  32'hFFFF_FFFF, 32'd1,         32'd1,         1);
        run_op("sltu",     4'd6,  32'hFFFF_FFFF, 32'd1,         32'd0,         1);
        run_op("passb",    4'd7,  32'h0000_AAAA, 32'h0000_1234, 32'h0000_1234, 1);
        run_op("rsvd13",   4'd13, 32'h1111_1111, 32'h2222_2222, 32'd0,         1);

`ifdef ALU_SEQ_MULDIV_EN
        run_op("mul",      4'd8,  32'd7,         32'd6,         32'd42,        33);
        run_op("mul_big",  4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         33);
        run_op("divu",     4'd9,  32'd100,       32'd7,         32'd14,        33);
        run_op("remu",     4'd10, 32'd100,       32'd7,         32'd2,         33);
        run_op("divu_z",   4'd9,  32'd5,         32'd0,         32'hFFFF_FFFF, 33);
        run_op("remu_z",   4'd10, 32'd5,         32'd0,         32'd5,         33);
`else
        run_op("mul_rsvd", 4'd8,  32'd7,         32'd6,         32'd0,         1);
        run_op("divu_rsvd",4'd9,  32'd100,       32'd7,         32'd0,         1);
`endif

        // Back-to-back issue with out_ready held high: one result per cycle.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op   = bb_op[i];
            srca = bb_a[i];
            srcb = bb_b[i];
            #1;
            chk($sformatf("b2b%0d.rdy", i), 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            chk($sformatf("b2b%0d.valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("b2b%0d.res", i),   64'(result),    64'(bb_exp[i]));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b.drain", 64'(out_valid), 64'd0);

        // Backpressure: result held for 3 cycles; next request waits.
        in_valid  = 1'b1;
        op        = 4'd0;
        srca      = 32'd3;
        srcb      = 32'd4;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("bp.first", 64'(result), 64'd7);
        op   = 4'd1;
        srca = 32'd10;
        srcb = 32'd1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d.rdy", k),   64'(in_ready),  64'd0);
            chk($sformatf("bp%0d.valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d.res", k),   64'(result),    64'd7);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_rdy", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.next_valid", 64'(out_valid), 64'd1);
        chk("bp.next_res",   64'(result),    64'd9);
        @(posedge clk); #1;
        chk("bp.drain", 64'(out_valid), 64'd0);

        // Flush.
`ifdef ALU_SEQ_MULDIV_EN
        // Flush in BUSY cycle 10 of a MUL.
        in_valid  = 1'b1;
        op        = 4'd8;
        srca      = 32'd7;
        srcb      = 32'd6;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("fl.busy_before", 64'(busy), 64'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = 4'd0;
        #1;
        chk("fl.rdy_blocked", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl.busy_after", 64'(busy), 64'd0);
`else
        // Flush while a result is pending in DONE.
        in_valid  = 1'b1;
        op        = 4'd0;
        srca      = 32'd1;
        srcb      = 32'd1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("fl.pending", 64'(out_valid), 64'd1);
        flush = 1'b1;
        srca  = 32'd5;
        srcb  = 32'd5;
        #1;
        chk("fl.rdy_blocked", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
`endif
        chk("fl.valid_drop", 64'(out_valid), 64'd0);
        vcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) vcnt++;
        end
        chk("fl.no_result", 64'(vcnt), 64'd0);
        chk("fl.ready", 64'(in_ready), 64'd1);
        run_op("fl.add", 4'd0, 32'd2, 32'd3, 32'd5, 1);

        // Asynchronous reset in the middle of an operation.
`ifdef ALU_SEQ_MULDIV_EN
        in_valid  = 1'b1;
        op        = 4'd9;
        srca      = 32'd100;
        srcb      = 32'd7;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rm.busy_before", 64'(busy), 64'd1);
`else
        in_valid  = 1'b1;
        op        = 4'd0;
        srca      = 32'd9;
        srcb      = 32'd9;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rm.pending", 64'(result), 64'd18);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("rm.valid",  64'(out_valid), 64'd0);
        chk("rm.busy",   64'(busy),      64'd0);
        chk("rm.result", 64'(result),    64'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rm.ready", 64'(in_ready), 64'd1);
        run_op("rm.sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
`ifdef ALU_SEQ_MULDIV_EN
        run_op("rm.divu", 4'd9, 32'd100, 32'd7, 32'd14, 33);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
